// File: rtl/wash_pkg.sv
// Shared phase and clock-select encodings for the washer controller, panel and driver blocks.
package wash_pkg;

  localparam int unsigned PHASE_W   = 3;
  localparam int unsigned CLK_SEL_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_e;

  typedef enum logic [CLK_SEL_W-1:0] {
    CLK_X1 = 2'd0,
    CLK_X2 = 2'd1,
    CLK_X4 = 2'd2,
    CLK_X8 = 2'd3
  } clk_sel_e;

endpackage

// File: rtl/wash_tick_gen.sv
// Tick prescaler: one tick every (PRE_DIV << div_sel) enabled cycles; clr restarts the count.
module wash_tick_gen
  import wash_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRE_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [CLK_SEL_W-1:0] div_sel,
  output logic                 tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_m1;

  assign div_m1 = (CNT_W'(PRE_DIV) << div_sel) - CNT_W'(1);

  // Combinational so the tick lands in the last cycle of each division period.
  assign tick = en && (cnt_q == div_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washer sequencer: FILL -> (WASH -> RINSE) x N -> SPIN, with pause and abort drain-spin.
module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRE_DIV = 1,
  parameter int unsigned T_FILL  = 120,
  parameter int unsigned T_WASH  = 300,
  parameter int unsigned T_RINSE = 120,
  parameter int unsigned T_SPIN  = 60,
  parameter int unsigned PASS_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CLK_SEL_W-1:0] clk_sel,
  input  logic                 start,
  input  logic [PASS_W-1:0]    pass_cnt,
  input  logic                 pause,
  input  logic                 abort,
  output logic                 busy,
  output logic [PHASE_W-1:0]   phase,
  output logic [PASS_W-1:0]    pass_idx,
  output logic                 wash_done,
  output logic                 aborted
);

  if ((64'(T_FILL) >= (64'(1) << CNT_W)) || (64'(T_WASH) >= (64'(1) << CNT_W)) ||
      (64'(T_RINSE) >= (64'(1) << CNT_W)) || (64'(T_SPIN) >= (64'(1) << CNT_W)) ||
      ((64'(PRE_DIV) << 3) >= (64'(1) << CNT_W))) begin : g_bad_param
    $error("wash_cycle_ctrl: phase duration or prescale does not fit CNT_W");
  end

  phase_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [PASS_W-1:0]     passes_q, passes_d;
  logic [CLK_SEL_W-1:0]  sel_q, sel_d;
  logic                  flag_q, flag_d;
  logic                  busy_q, done_q, done_d, abt_q, abt_d;
  logic                  tick_c, phase_end_c, clr_c;
  logic [CNT_W-1:0]      t_last_c;
  logic [PASS_W:0]       pass_nxt_c;

  wash_tick_gen #(
    .CNT_W   (CNT_W),
    .PRE_DIV (PRE_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (busy_q && !pause),
    .clr     (clr_c),
    .div_sel (sel_q),
    .tick    (tick_c)
  );

  // Last timer value of the current phase.
  always_comb begin
    t_last_c = '0;
    unique case (state_q)
      PH_FILL:  t_last_c = CNT_W'(T_FILL - 1);
      PH_WASH:  t_last_c = CNT_W'(T_WASH - 1);
      PH_RINSE: t_last_c = CNT_W'(T_RINSE - 1);
      PH_SPIN:  t_last_c = CNT_W'(T_SPIN - 1);
      default:  t_last_c = '0;
    endcase
  end

  assign phase_end_c = tick_c && (timer_q == t_last_c);
  assign pass_nxt_c  = {1'b0, pass_q} + (PASS_W + 1)'(1);
  assign clr_c       = (state_d != state_q);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    sel_d    = sel_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    abt_d    = 1'b0;
    unique case (state_q)
      PH_IDLE: begin
        if (start) begin
          state_d  = PH_FILL;
          timer_d  = '0;
          pass_d   = '0;
          flag_d   = 1'b0;
          sel_d    = clk_sel;
          passes_d = (pass_cnt == '0) ? PASS_W'(1) : pass_cnt;
        end
      end
      PH_FILL, PH_WASH, PH_RINSE: begin
        // Abort takes effect even while paused.
        if (abort) begin
          state_d = PH_SPIN;
          timer_d = '0;
          pass_d  = '0;
          flag_d  = 1'b1;
        end else if (phase_end_c) begin
          timer_d = '0;
          if (state_q == PH_FILL) begin
            state_d = PH_WASH;
          end else if (state_q == PH_WASH) begin
            state_d = PH_RINSE;
          end else if (pass_nxt_c < {1'b0, passes_q}) begin
            state_d = PH_WASH;
            pass_d  = pass_nxt_c[PASS_W-1:0];
          end else begin
            state_d = PH_SPIN;
            pass_d  = '0;
          end
        end else if (tick_c) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      PH_SPIN: begin
        if (phase_end_c) begin
          state_d = PH_IDLE;
          timer_d = '0;
          done_d  = !flag_q;
          abt_d   = flag_q;
          flag_d  = 1'b0;
        end else if (tick_c) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PH_IDLE;
        timer_d = '0;
        pass_d  = '0;
        flag_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PH_IDLE;
      timer_q  <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      sel_q    <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      sel_q    <= sel_d;
      flag_q   <= flag_d;
      busy_q   <= (state_d != PH_IDLE);
      done_q   <= done_d;
      abt_q    <= abt_d;
    end
  end

  assign phase     = state_q;
  assign busy      = busy_q;
  assign pass_idx  = pass_q;
  assign wash_done = done_q;
  assign aborted   = abt_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: directed scenarios plus random traffic against a cycles-remaining model.
module tb_wash_cycle_ctrl;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PRE_DIV = 2;
  localparam int unsigned T_FILL  = 3;
  localparam int unsigned T_WASH  = 5;
  localparam int unsigned T_RINSE = 3;
  localparam int unsigned T_SPIN  = 2;
  localparam int unsigned PASS_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        clk_sel;
  logic              start;
  logic [PASS_W-1:0] pass_cnt;
  logic              pause;
  logic              abort;
  logic              busy;
  logic [2:0]        phase;
  logic [PASS_W-1:0] pass_idx;
  logic              wash_done;
  logic              aborted;

  wash_cycle_ctrl #(
    .CNT_W   (CNT_W),
    .PRE_DIV (PRE_DIV),
    .T_FILL  (T_FILL),
    .T_WASH  (T_WASH),
    .T_RINSE (T_RINSE),
    .T_SPIN  (T_SPIN),
    .PASS_W  (PASS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_sel   (clk_sel),
    .start     (start),
    .pass_cnt  (pass_cnt),
    .pause     (pause),
    .abort     (abort),
    .busy      (busy),
    .phase     (phase),
    .pass_idx  (pass_idx),
    .wash_done (wash_done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: phase code (0 idle,1 fill,2 wash,3 rinse,4 spin) and cycles left in it.
  int m_phase, m_left, m_passes, m_pidx, m_sel;
  bit m_flag, m_done, m_abt;

  function automatic int dur(input int ph);
    int t;
    case (ph)
      1:       t = T_FILL;
      2:       t = T_WASH;
      3:       t = T_RINSE;
      default: t = T_SPIN;
    endcase
    return t * (PRE_DIV << m_sel);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_passes = 1; m_pidx = 0; m_sel = 0;
    m_flag = 0; m_done = 0; m_abt = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    m_abt  = 0;
    if (m_phase == 0) begin
      if (start) begin
        m_phase  = 1;
        m_sel    = int'(clk_sel);
        m_passes = (pass_cnt == 0) ? 1 : int'(pass_cnt);
        m_pidx   = 0;
        m_flag   = 0;
        m_left   = dur(1);
      end
    end else if (abort && m_phase != 4) begin
      m_phase = 4;
      m_flag  = 1;
      m_pidx  = 0;
      m_left  = dur(4);
    end else if (!pause) begin
      m_left--;
      if (m_left == 0) begin
        case (m_phase)
          1: m_phase = 2;
          2: m_phase = 3;
          3: begin
            if (m_pidx + 1 < m_passes) begin
              m_phase = 2;
              m_pidx++;
            end else begin
              m_phase = 4;
              m_pidx  = 0;
            end
          end
          default: begin
            m_phase = 0;
            m_done  = !m_flag;
            m_abt   = m_flag;
            m_flag  = 0;
          end
        endcase
        if (m_phase != 0) m_left = dur(m_phase);
      end
    end
  endtask

  task automatic compare();
    check("phase", int'(phase), m_phase);
    check("busy", int'(busy), int'(m_phase != 0));
    check("pass_idx", int'(pass_idx), m_pidx);
    check("wash_done", int'(wash_done), int'(m_done));
    check("aborted", int'(aborted), int'(m_abt));
  endtask

  int busy_cnt, done_cnt, abt_cnt;

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    compare();
    if (busy)      busy_cnt++;
    if (wash_done) done_cnt++;
    if (aborted)   abt_cnt++;
  endtask

  task automatic go(input int sel, input int pc);
    busy_cnt = 0; done_cnt = 0; abt_cnt = 0;
    clk_sel  = 2'(sel);
    pass_cnt = PASS_W'(pc);
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input bit scramble);
    int n = 0;
    while (busy && n < 400) begin
      if (scramble) begin
        clk_sel  = 2'($urandom);
        pass_cnt = PASS_W'($urandom);
      end
      cyc();
      n++;
    end
    check("idle_within_budget", int'(busy), 0);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    clk_sel = '0; pass_cnt = '0;
    model_reset();
    #1;
    compare();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Single pass at 1x
    go(0, 1);
    wait_idle(1'b0);
    check("t1_busy_cycles", busy_cnt, 26);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_abort_pulses", abt_cnt, 0);

    // Two passes at 2x
    go(1, 2);
    wait_idle(1'b0);
    check("t2_busy_cycles", busy_cnt, 84);
    check("t2_done_pulses", done_cnt, 1);

    // pass_cnt=0 behaves as 1; inputs churn while busy
    go(0, 0);
    wait_idle(1'b1);
    check("t3_busy_cycles", busy_cnt, 26);
    clk_sel = '0; pass_cnt = '0;

    // Pause 7 cycles inside WASH
    go(0, 1);
    repeat (7) cyc();
    check("t4_in_wash", int'(phase), 2);
    pause = 1'b1;
    repeat (7) cyc();
    pause = 1'b0;
    wait_idle(1'b0);
    check("t4_busy_cycles", busy_cnt, 33);
    check("t4_done_pulses", done_cnt, 1);

    // Pause 3 cycles inside SPIN
    go(0, 1);
    repeat (22) cyc();
    check("t4_in_spin", int'(phase), 4);
    pause = 1'b1;
    repeat (3) cyc();
    pause = 1'b0;
    wait_idle(1'b0);
    check("t4s_busy_cycles", busy_cnt, 29);

    // Abort during WASH
    go(0, 1);
    repeat (9) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t5_spin_after_abort", int'(phase), 4);
    wait_idle(1'b0);
    check("t5_busy_cycles", busy_cnt, 14);
    check("t5_done_pulses", done_cnt, 0);
    check("t5_abort_pulses", abt_cnt, 1);

    // Abort together with pause
    go(0, 1);
    repeat (3) cyc();
    pause = 1'b1; abort = 1'b1;
    cyc();
    pause = 1'b0; abort = 1'b0;
    check("t5_abort_beats_pause", int'(phase), 4);
    wait_idle(1'b0);
    check("t5p_abort_pulses", abt_cnt, 1);

    // Start while busy, then reset mid-RINSE
    go(0, 1);
    start = 1'b1;
    repeat (17) cyc();
    start = 1'b0;
    check("t6_in_rinse", int'(phase), 3);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    check("t6_no_done_after_rst", done_cnt, 0);
    check("t6_no_abort_after_rst", abt_cnt, 0);

    // start+abort together in IDLE
    busy_cnt = 0; done_cnt = 0; abt_cnt = 0;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0;
    check("t6_fill_first", int'(phase), 1);
    cyc();
    abort = 1'b0;
    check("t6_then_spin", int'(phase), 4);
    wait_idle(1'b0);
    check("t6_abort_pulses", abt_cnt, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      clk_sel  = 2'($urandom);
      pass_cnt = PASS_W'($urandom);
      rst_n    = ($urandom_range(0, 599) != 0);
      if (!rst_n) begin
        #1;
        model_reset();
        compare();
      end
      cyc();
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
